// File: rtl/dsa_coord_gen_simd.sv
// rtl/dsa_coord_gen_simd.sv - N-lane raster coordinate/weight generator for bilinear interpolation
// Optional half-pixel centre alignment: define COORD_GEN_CENTER_ALIGN_EN.
module dsa_coord_gen_simd #(
  parameter int N  = 4,
  parameter int CW = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_start,
  input  logic [CW-1:0]        i_src_w,
  input  logic [CW-1:0]        i_src_h,
  input  logic [CW-1:0]        i_dst_w,
  input  logic [CW-1:0]        i_dst_h,
  input  logic [15:0]          i_step_x,
  input  logic [15:0]          i_step_y,
  input  logic                 i_out_ready,
  output logic                 o_out_valid,
  output logic [N-1:0]         o_lane_en,
  output logic [CW-1:0]        o_dst_x,
  output logic [CW-1:0]        o_dst_y,
  output logic [N-1:0][CW-1:0] o_x0,
  output logic [N-1:0][CW-1:0] o_x1,
  output logic [N-1:0][CW-1:0] o_y0,
  output logic [N-1:0][CW-1:0] o_y1,
  output logic [N-1:0][15:0]   o_a,
  output logic [N-1:0][15:0]   o_b,
  output logic                 o_busy,
  output logic                 o_frame_done
);

`ifdef COORD_GEN_CENTER_ALIGN_EN
  localparam int AW = 25;
`else
  localparam int AW = 24;
`endif

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]            r_state;
  logic [CW-1:0]         r_src_w, r_src_h, r_dst_w, r_dst_h;
  logic [15:0]           r_step_x, r_step_y;
  logic [CW-1:0]         r_dx, r_dy;
  logic [AW-1:0]         r_xb, r_ya;
  logic [N-1:0][AW-1:0]  r_off;

  logic [AW-1:0]         w_xb_init, w_ya_init, w_xstep;
  logic                  w_more_x;
  logic [N-1:0][2*CW+7:0] w_xc;
  logic [2*CW+7:0]       w_yc;

`ifdef COORD_GEN_CENTER_ALIGN_EN
  assign w_xb_init = AW'(r_step_x >> 1) - AW'(128);
  assign w_ya_init = AW'(r_step_y >> 1) - AW'(128);
`else
  assign w_xb_init = '0;
  assign w_ya_init = '0;
`endif

  assign w_xstep  = AW'(r_step_x) * AW'(N);
  assign w_more_x = ({1'b0, r_dx} + (CW+1)'(N)) < {1'b0, r_dst_w};

  // Returns {c0, c1, frac}: integer part clamped to lim, neighbour, fraction zeroed at the edge.
  function automatic logic [2*CW+7:0] f_clamp(input logic [AW-1:0] s, input logic [CW-1:0] lim);
    logic [CW-1:0] ip, c0, c1;
    logic [7:0]    fr;
    ip = CW'(s[23:8]);
    fr = s[7:0];
`ifdef COORD_GEN_CENTER_ALIGN_EN
    if (s[AW-1]) begin
      ip = '0;
      fr = '0;
    end
`endif
    if (ip >= lim) begin
      c0 = lim;
      fr = '0;
    end else begin
      c0 = ip;
    end
    c1 = (c0 < lim) ? c0 + CW'(1) : lim;
    return {c0, c1, fr};
  endfunction

  always_comb begin
    w_yc = f_clamp(r_ya, r_src_h - CW'(1));
    for (int i = 0; i < N; i++) begin
      w_xc[i] = f_clamp(r_xb + r_off[i], r_src_w - CW'(1));
    end
  end

  always_comb begin
    o_out_valid  = 1'b0;
    o_lane_en    = '0;
    o_dst_x      = '0;
    o_dst_y      = '0;
    o_x0         = '0;
    o_x1         = '0;
    o_y0         = '0;
    o_y1         = '0;
    o_a          = '0;
    o_b          = '0;
    o_busy       = (r_state == S_LOAD) || (r_state == S_RUN);
    o_frame_done = (r_state == S_DONE);
    if (r_state == S_RUN) begin
      o_out_valid = 1'b1;
      o_dst_x     = r_dx;
      o_dst_y     = r_dy;
      for (int i = 0; i < N; i++) begin
        o_lane_en[i] = ({1'b0, r_dx} + (CW+1)'(i)) < {1'b0, r_dst_w};
        o_x0[i]      = w_xc[i][2*CW+7 -: CW];
        o_x1[i]      = w_xc[i][CW+7 -: CW];
        o_a[i]       = {8'h00, w_xc[i][7:0]};
        o_y0[i]      = w_yc[2*CW+7 -: CW];
        o_y1[i]      = w_yc[CW+7 -: CW];
        o_b[i]       = {8'h00, w_yc[7:0]};
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= S_IDLE;
      r_src_w  <= '0;
      r_src_h  <= '0;
      r_dst_w  <= '0;
      r_dst_h  <= '0;
      r_step_x <= '0;
      r_step_y <= '0;
      r_dx     <= '0;
      r_dy     <= '0;
      r_xb     <= '0;
      r_ya     <= '0;
      r_off    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_src_w  <= i_src_w;
            r_src_h  <= i_src_h;
            r_dst_w  <= i_dst_w;
            r_dst_h  <= i_dst_h;
            r_step_x <= i_step_x;
            r_step_y <= i_step_y;
            r_dx     <= '0;
            r_dy     <= '0;
            r_state  <= (i_dst_w == '0 || i_dst_h == '0) ? S_DONE : S_LOAD;
          end
        end
        S_LOAD: begin
          for (int i = 0; i < N; i++) begin
            r_off[i] <= AW'(r_step_x) * AW'(i);
          end
          r_xb    <= w_xb_init;
          r_ya    <= w_ya_init;
          r_state <= S_RUN;
        end
        S_RUN: begin
          if (i_out_ready) begin
            if (w_more_x) begin
              r_dx <= r_dx + CW'(N);
              r_xb <= r_xb + w_xstep;
            end else begin
              r_dx <= '0;
              r_xb <= w_xb_init;
              r_dy <= r_dy + CW'(1);
              r_ya <= r_ya + AW'(r_step_y);
              if (r_dy == r_dst_h - CW'(1)) r_state <= S_DONE;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dsa_coord_gen_simd.sv
// tb/tb_dsa_coord_gen_simd.sv - scoreboard bench for dsa_coord_gen_simd
module tb_dsa_coord_gen_simd;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic [15:0] src_w = 16'd1, src_h = 16'd1, dst_w = 16'd0, dst_h = 16'd0;
  logic [15:0] step_x = 16'd0, step_y = 16'd0;
  logic out_ready = 1'b1;
  logic out_valid, busy, frame_done;
  logic [3:0] lane_en;
  logic [15:0] dst_x, dst_y;
  logic [3:0][15:0] x0, x1, y0, y1, a, b;

  always #5 clk = ~clk;

  dsa_coord_gen_simd #(.N(4), .CW(16)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start),
    .i_src_w(src_w), .i_src_h(src_h), .i_dst_w(dst_w), .i_dst_h(dst_h),
    .i_step_x(step_x), .i_step_y(step_y), .i_out_ready(out_ready),
    .o_out_valid(out_valid), .o_lane_en(lane_en), .o_dst_x(dst_x), .o_dst_y(dst_y),
    .o_x0(x0), .o_x1(x1), .o_y0(y0), .o_y1(y1), .o_a(a), .o_b(b),
    .o_busy(busy), .o_frame_done(frame_done)
  );

  typedef struct packed {
    logic [15:0]      dx, dy;
    logic [3:0]       en, cm;
    logic [3:0][15:0] ex0, ex1, ea;
    logic             chky;
    logic [15:0]      ey0, ey1, eb;
  } beat_t;

  beat_t q[$];
  int n_cmp = 0, n_bad = 0;
  int cyc = 0, hs_cnt = 0, done_cnt = 0, stall_cnt = 0;
  int last_hs_cyc = -10, done_cyc = -10, first_valid_cyc = -1, start_cyc = 0;
  logic stalled = 1'b0;
  logic [419:0] snap, cur;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      stalled = 1'b0;
    end else begin
      cur = {lane_en, dst_x, dst_y, x0, x1, y0, y1, a, b};
      if (stalled) begin
        stall_cnt++;
        chk("stall_valid_held", out_valid, 1);
        chk("stall_outputs_stable", cur == snap, 1);
      end
      if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (out_valid && out_ready) begin
        hs_cnt++;
        last_hs_cyc = cyc;
        chk("beat_expected", q.size() != 0, 1);
        if (q.size() != 0) begin
          beat_t e;
          e = q.pop_front();
          chk("dst_x", dst_x, e.dx);
          chk("dst_y", dst_y, e.dy);
          chk("lane_en", lane_en, e.en);
          for (int i = 0; i < 4; i++) begin
            if (e.cm[i]) begin
              chk("x0", x0[i], e.ex0[i]);
              chk("x1", x1[i], e.ex1[i]);
              chk("a", a[i], e.ea[i]);
            end
            if (e.chky) begin
              chk("y0", y0[i], e.ey0);
              chk("y1", y1[i], e.ey1);
              chk("b", b[i], e.eb);
            end
          end
        end
      end
      if (frame_done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      stalled = out_valid && !out_ready;
      snap = cur;
    end
  end

  task automatic push(input logic [15:0] dx, dy, input logic [3:0] en, cm,
                      input logic [63:0] ex0, ex1, ea, input logic chky,
                      input logic [15:0] ey0, ey1, eb);
    beat_t e;
    e.dx = dx; e.dy = dy; e.en = en; e.cm = cm;
    e.ex0 = ex0; e.ex1 = ex1; e.ea = ea;
    e.chky = chky; e.ey0 = ey0; e.ey1 = ey1; e.eb = eb;
    q.push_back(e);
  endtask

  task automatic start_frame(input logic [15:0] sw, sh, dw, dh, sx, sy);
    @(posedge clk); #1;
    src_w = sw; src_h = sh; dst_w = dw; dst_h = dh; step_x = sx; step_y = sy;
    first_valid_cyc = -1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    start_cyc = cyc;
  endtask

  task automatic wait_done(input bit zero_dim);
    int d0, n;
    d0 = done_cnt - ((done_cyc == start_cyc) ? 1 : 0);
    n = 0;
    while (done_cnt == d0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    chk("frame_done_seen", done_cnt > d0, 1);
    if (zero_dim) begin
      chk("zero_dim_done_time", done_cyc, start_cyc);
      chk("zero_dim_no_valid", first_valid_cyc, 64'hFFFF_FFFF_FFFF_FFFF);
    end else begin
      chk("first_valid_latency", first_valid_cyc, start_cyc + 1);
      chk("done_after_last_beat", done_cyc, last_hs_cyc + 1);
    end
    chk("scoreboard_drained", q.size(), 0);
    #1;
    chk("idle_busy", busy, 0);
  endtask

  task automatic chk_reset_vals();
    chk("rst_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_lane_en", lane_en, 0);
    chk("rst_dst_x", dst_x, 0);
    chk("rst_dst_y", dst_y, 0);
    chk("rst_x0", x0, 0);
    chk("rst_x1", x1, 0);
    chk("rst_y0", y0, 0);
    chk("rst_y1", y1, 0);
    chk("rst_a", a, 0);
    chk("rst_b", b, 0);
  endtask

  initial begin
    logic [3:0][15:0] px0, px1;
    int ey0[3] = '{0, 0, 1};
    int ey1[3] = '{1, 1, 2};
    int eb[3]  = '{0, 192, 128};
    int h0, s0, d0, n;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk_reset_vals();

    // dst 4x1 from src 2x1, half-step horizontally
`ifdef COORD_GEN_CENTER_ALIGN_EN
    push(16'd0, 16'd0, 4'b1111, 4'b1111,
         {16'd1, 16'd0, 16'd0, 16'd0}, {16'd1, 16'd1, 16'd1, 16'd1},
         {16'd0, 16'd192, 16'd64, 16'd0}, 1'b1, 16'd0, 16'd0, 16'd0);
`else
    push(16'd0, 16'd0, 4'b1111, 4'b1111,
         {16'd1, 16'd1, 16'd0, 16'd0}, {16'd1, 16'd1, 16'd1, 16'd1},
         {16'd0, 16'd0, 16'd128, 16'd0}, 1'b1, 16'd0, 16'd0, 16'd0);
`endif
    start_frame(16'd2, 16'd1, 16'd4, 16'd1, 16'd128, 16'd0);
    chk("load_busy", busy, 1);
    chk("load_no_valid", out_valid, 0);
    wait_done(1'b0);

`ifndef COORD_GEN_CENTER_ALIGN_EN
    // 6-wide row: second beat has only two live lanes
    push(16'd0, 16'd0, 4'b1111, 4'b1111,
         {16'd3, 16'd2, 16'd1, 16'd0}, {16'd4, 16'd3, 16'd2, 16'd1}, 64'd0,
         1'b1, 16'd0, 16'd0, 16'd0);
    push(16'd4, 16'd0, 4'b0011, 4'b0011,
         {16'd7, 16'd6, 16'd5, 16'd4}, {16'd8, 16'd7, 16'd6, 16'd5}, 64'd0,
         1'b1, 16'd0, 16'd0, 16'd0);
    start_frame(16'd16, 16'd1, 16'd6, 16'd1, 16'd256, 16'd0);
    wait_done(1'b0);

    // Vertical fractions with step_y = 0.75
    for (int r = 0; r < 3; r++) begin
      push(16'd0, 16'(r), 4'b1111, 4'b1111,
           {16'd3, 16'd2, 16'd1, 16'd0}, {16'd3, 16'd3, 16'd2, 16'd1}, 64'd0,
           1'b1, 16'(ey0[r]), 16'(ey1[r]), 16'(eb[r]));
    end
    start_frame(16'd4, 16'd3, 16'd4, 16'd3, 16'd256, 16'd192);
    wait_done(1'b0);

    // 8x3 frame with a 5-cycle back-pressure window
    for (int r = 0; r < 3; r++) begin
      for (int g = 0; g < 2; g++) begin
        for (int i = 0; i < 4; i++) begin
          px0[i] = 16'(4 * g + i);
          px1[i] = 16'(4 * g + i + 1);
        end
        push(16'(4 * g), 16'(r), 4'b1111, 4'b1111, px0, px1, 64'd0,
             1'b1, 16'(r), 16'(r + 1), 16'd0);
      end
    end
    h0 = hs_cnt;
    s0 = stall_cnt;
    start_frame(16'd16, 16'd16, 16'd8, 16'd3, 16'd256, 16'd256);
    n = 0;
    while (hs_cnt < h0 + 2 && n < 50) begin
      @(posedge clk);
      n++;
    end
    #1 out_ready = 1'b0;
    repeat (5) @(posedge clk);
    #1 out_ready = 1'b1;
    wait_done(1'b0);
    chk("stall_beat_count", hs_cnt - h0, 6);
    chk("stall_cycles", stall_cnt - s0, 5);
`endif

    // Zero-width and zero-height frames
    start_frame(16'd4, 16'd4, 16'd0, 16'd3, 16'd256, 16'd256);
    wait_done(1'b1);
    start_frame(16'd4, 16'd4, 16'd8, 16'd0, 16'd256, 16'd256);
    wait_done(1'b1);

    // Reset in the middle of a frame
    for (int r = 0; r < 3; r++) begin
      for (int g = 0; g < 2; g++) begin
        push(16'(4 * g), 16'(r), 4'b1111, 4'b0000, 64'd0, 64'd0, 64'd0,
             1'b0, 16'd0, 16'd0, 16'd0);
      end
    end
    h0 = hs_cnt;
    start_frame(16'd16, 16'd16, 16'd8, 16'd3, 16'd256, 16'd256);
    n = 0;
    while (hs_cnt < h0 + 2 && n < 50) begin
      @(posedge clk);
      n++;
    end
    chk("pre_reset_beats", hs_cnt >= h0 + 2, 1);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    q.delete();
    d0 = done_cnt;
    chk_reset_vals();
    repeat (10) @(posedge clk);
    #1;
    chk("no_done_after_reset", done_cnt, d0);
    chk("stays_idle_valid", out_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
